// File: rtl/div_pkg.sv
// Shared types and sign helpers for the sequential divider.
// The helpers work on a wide container; callers zero-extend and keep the low DW bits.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int MAX_DW = 64;

  function automatic logic [MAX_DW-1:0] cond_neg(input logic [MAX_DW-1:0] x,
                                                 input logic              neg);
    return neg ? (~x + {{(MAX_DW-1){1'b0}}, 1'b1}) : x;
  endfunction

  // Low DW bits of the result are the unsigned magnitude of a DW-bit operand.
  function automatic logic [MAX_DW-1:0] magnitude(input logic [MAX_DW-1:0] x,
                                                  input logic              sign_bit,
                                                  input logic              is_signed);
    return cond_neg(x, is_signed & sign_bit);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift {rem, quo} left, subtract the divisor if it fits.
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   rem_i,
  input  logic [DW-1:0] quo_i,
  input  logic [DW-1:0] dvs_i,
  output logic [DW:0]   rem_o,
  output logic [DW-1:0] quo_o
);

  logic [DW:0] shifted;
  logic [DW:0] dvs_ext;
  logic        take;
  logic        rem_msb_unused;

  // The incoming remainder is always below the divisor, so its top bit is zero.
  assign rem_msb_unused = rem_i[DW];

  assign shifted = {rem_i[DW-1:0], quo_i[DW-1]};
  assign dvs_ext = {1'b0, dvs_i};
  assign take    = (shifted >= dvs_ext);
  assign rem_o   = take ? (shifted - dvs_ext) : shifted;
  assign quo_o   = {quo_i[DW-2:0], take};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned integer divider, UNROLL quotient bits per clock.
// Handshake: a transfer happens on any rising edge where valid && ready; valid never waits on ready.
module div_seq
  import div_pkg::*;
#(
  parameter int DW     = 8,
  parameter int UNROLL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  input  logic          is_signed,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow,
  output logic [1:0]    dbg_state
);

  localparam int N     = DW / UNROLL;
  localparam int CNT_W = $clog2(N + 1);

  if (DW < 2 || DW > MAX_DW) begin : g_bad_dw
    $error("div_seq: DW must be in 2..%0d", MAX_DW);
  end
  if (UNROLL < 1 || (DW % UNROLL) != 0) begin : g_bad_unroll
    $error("div_seq: DW must be a multiple of UNROLL");
  end

  localparam logic [1:0]       ST_IDLE = S_IDLE;
  localparam logic [1:0]       ST_CALC = S_CALC;
  localparam logic [1:0]       ST_FIX  = S_FIX;
  localparam logic [1:0]       ST_DONE = S_DONE;
  localparam logic [CNT_W-1:0] CNT_N   = CNT_W'(N);
  localparam logic [DW-1:0]    MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DW-1:0] dvd_q;
  logic [DW-1:0] dvd_mag_q;
  logic [DW-1:0] dvs_mag_q;
  logic          quo_neg_q;
  logic          rem_neg_q;
  logic          dz_q;
  logic          ovf_q;
  logic [DW:0]   rem_q;
  logic [DW-1:0] quo_q;

  logic [DW-1:0] quotient_q;
  logic [DW-1:0] remainder_q;
  logic          div_by_zero_q;
  logic          overflow_q;

  logic          accept;
  logic          release_out;

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign accept      = in_valid & in_ready;
  assign release_out = out_valid & out_ready;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;
  assign dbg_state   = state_q;

  // Operand magnitudes, computed from the live inputs and captured on accept.
  logic [MAX_DW-1:0] dvd_mag_w;
  logic [MAX_DW-1:0] dvs_mag_w;
  assign dvd_mag_w = magnitude(MAX_DW'(dividend), dividend[DW-1], is_signed);
  assign dvs_mag_w = magnitude(MAX_DW'(divisor), divisor[DW-1], is_signed);

  // Restoring step chain: UNROLL steps resolved per CALC cycle.
  logic [DW:0]   rem_chain [UNROLL+1];
  logic [DW-1:0] quo_chain [UNROLL+1];

  assign rem_chain[0] = rem_q;
  assign quo_chain[0] = quo_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    div_step #(.DW(DW)) u_step (
      .rem_i (rem_chain[i]),
      .quo_i (quo_chain[i]),
      .dvs_i (dvs_mag_q),
      .rem_o (rem_chain[i+1]),
      .quo_o (quo_chain[i+1])
    );
  end

  // Sign fix-up and special-case override applied in FIX.
  logic [MAX_DW-1:0] q_signed_w;
  logic [MAX_DW-1:0] r_signed_w;
  logic [DW-1:0]     q_fix;
  logic [DW-1:0]     r_fix;
  logic              wide_unused;

  assign q_signed_w = cond_neg(MAX_DW'(quo_q), quo_neg_q);
  assign r_signed_w = cond_neg(MAX_DW'(rem_q[DW-1:0]), rem_neg_q);
  assign wide_unused = ^{q_signed_w, r_signed_w, dvd_mag_w, dvs_mag_w};

  always_comb begin
    q_fix = q_signed_w[DW-1:0];
    r_fix = r_signed_w[DW-1:0];
    if (dz_q) begin
      q_fix = '1;
      r_fix = dvd_q;
    end else if (ovf_q) begin
      q_fix = dvd_q;
      r_fix = '0;
    end
  end

  // Control FSM. CALC spends one cycle loading {rem, quo} and then N step cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CALC;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_N) begin
          state_d = ST_FIX;
          cnt_d   = cnt_q;
        end
      end
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: begin
        if (release_out) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q         <= '0;
      dvd_mag_q     <= '0;
      dvs_mag_q     <= '0;
      quo_neg_q     <= 1'b0;
      rem_neg_q     <= 1'b0;
      dz_q          <= 1'b0;
      ovf_q         <= 1'b0;
      rem_q         <= '0;
      quo_q         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            dvd_q     <= dividend;
            dvd_mag_q <= dvd_mag_w[DW-1:0];
            dvs_mag_q <= dvs_mag_w[DW-1:0];
            quo_neg_q <= is_signed & (dividend[DW-1] ^ divisor[DW-1]);
            rem_neg_q <= is_signed & dividend[DW-1];
            dz_q      <= (divisor == '0);
            ovf_q     <= is_signed && (dividend == MIN_NEG) && (divisor == '1);
          end
        end
        ST_CALC: begin
          if (cnt_q == '0) begin
            rem_q <= '0;
            quo_q <= dvd_mag_q;
          end else begin
            rem_q <= rem_chain[UNROLL];
            quo_q <= quo_chain[UNROLL];
          end
        end
        ST_FIX: begin
          quotient_q    <= q_fix;
          remainder_q   <= r_fix;
          div_by_zero_q <= dz_q;
          overflow_q    <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed cases on DW=8/UNROLL=1 plus random traffic on
// several DW/UNROLL configurations, all checked against an arithmetic reference.
module tb_div_seq;

  logic       clk;
  logic       rst_n;
  logic       rst_g_n;
  logic       in_valid, in_ready, is_signed, out_valid, out_ready;
  logic       div_by_zero, overflow;
  logic [7:0] dividend, divisor, quotient, remainder;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int gen_done = 0;

  div_seq #(.DW(8), .UNROLL(1)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Truncating division straight from the arithmetic definition.
  function automatic void ref_div(input int dw, input logic [63:0] a, input logic [63:0] b,
                                  input logic s, output logic [63:0] q, output logic [63:0] r,
                                  output logic dz, output logic ov);
    longint     sa, sb;
    logic [63:0] mask, minneg;
    mask   = (64'd1 << dw) - 64'd1;
    minneg = 64'd1 << (dw - 1);
    sa = (s && a[dw-1]) ? longint'(a) - longint'(64'd1 << dw) : longint'(a);
    sb = (s && b[dw-1]) ? longint'(b) - longint'(64'd1 << dw) : longint'(b);
    dz = (b == 64'd0);
    ov = s && (a == minneg) && (b == mask);
    if (dz) begin
      q = mask;
      r = a;
    end else if (ov) begin
      q = a;
      r = 64'd0;
    end else begin
      q = 64'(sa / sb) & mask;
      r = 64'(sa % sb) & mask;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    dividend  = 8'($urandom);
    divisor   = 8'($urandom);
    is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
    chk({tag, "_vld_after"}, 64'(out_valid), 64'd0);
  endtask

  task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input logic eov);
    int lat;
    start_op(a, b, s);
    chk({tag, "_busy"}, 64'(in_ready), 64'd0);
    wait_result(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd10);
    chk({tag, "_q"}, 64'(quotient), 64'(eq));
    chk({tag, "_r"}, 64'(remainder), 64'(er));
    chk({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
    chk({tag, "_ov"}, 64'(overflow), 64'(eov));
    handshake(tag);
  endtask

  // ---------------- main directed + random sequence ----------------
  initial begin
    int          lat;
    int          spurious;
    logic [7:0]  a, b;
    logic        s;
    logic [63:0] eq, er;
    logic        edz, eov;

    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    rst_n     = 1'b0;
    rst_g_n   = 1'b0;
    #2;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_q", 64'(quotient), 64'd0);
    chk("rst_r", 64'(remainder), 64'd0);
    chk("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    rst_g_n = 1'b1;

    check_op("u100_7", 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0);
    check_op("sm7_2", 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 1'b0);
    check_op("s7_m2", 8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 1'b0);
    check_op("dz_u", 8'h55, 8'h00, 1'b0, 8'hFF, 8'h55, 1'b1, 1'b0);
    check_op("dz_s", 8'h55, 8'h00, 1'b1, 8'hFF, 8'h55, 1'b1, 1'b0);
    check_op("u80_ff", 8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0);

    // Back-pressure: hold DONE, with a new request already waiting.
    start_op(8'd200, 8'd13, 1'b0);
    wait_result(lat);
    chk("hold_lat", 64'(lat), 64'd10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      dividend  = 8'd77;
      divisor   = 8'd5;
      is_signed = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_vld", 64'(out_valid), 64'd1);
      chk("hold_q", 64'(quotient), 64'd15);
      chk("hold_r", 64'(remainder), 64'd5);
      chk("hold_rdy", 64'(in_ready), 64'd0);
    end
    handshake("hold");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_busy", 64'(in_ready), 64'd0);
    wait_result(lat);
    chk("b2b_lat", 64'(lat), 64'd10);
    chk("b2b_q", 64'(quotient), 64'd15);
    chk("b2b_r", 64'(remainder), 64'd2);
    handshake("b2b");

    check_op("ovf_s", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1);

    // Asynchronous abort in the middle of CALC.
    start_op(8'd250, 8'd3, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_vld", 64'(out_valid), 64'd0);
    chk("abort_rdy", 64'(in_ready), 64'd1);
    chk("abort_q", 64'(quotient), 64'd0);
    chk("abort_ov", 64'(overflow), 64'd0);
    chk("abort_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) spurious++;
    end
    chk("abort_no_out", 64'(spurious), 64'd0);
    check_op("u200_13", 8'd200, 8'd13, 1'b0, 8'd15, 8'd5, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        a = 8'h80;
        b = 8'hFF;
      end
      ref_div(8, 64'(a), 64'(b), s, eq, er, edz, eov);
      check_op($sformatf("rnd%0d", i), a, b, s, eq[7:0], er[7:0], edz, eov);
    end

    lat = 0;
    while (gen_done < 4 && lat < 5000) begin
      @(posedge clk);
      lat++;
    end
    chk("cfg_done", 64'(gen_done), 64'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // ---------------- other configurations, random traffic ----------------
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int GDW  = (g < 2) ? 8 : 16;
    localparam int GUN  = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 4;
    localparam int GLAT = GDW / GUN + 2;

    logic           g_in_valid, g_in_ready, g_is_signed, g_out_valid, g_out_ready;
    logic           g_dz, g_ov;
    logic [GDW-1:0] g_a, g_b, g_q, g_r;
    logic [1:0]     g_state;

    div_seq #(.DW(GDW), .UNROLL(GUN)) u_dut (
      .clk         (clk),
      .rst_n       (rst_g_n),
      .in_valid    (g_in_valid),
      .in_ready    (g_in_ready),
      .dividend    (g_a),
      .divisor     (g_b),
      .is_signed   (g_is_signed),
      .out_valid   (g_out_valid),
      .out_ready   (g_out_ready),
      .quotient    (g_q),
      .remainder   (g_r),
      .div_by_zero (g_dz),
      .overflow    (g_ov),
      .dbg_state   (g_state)
    );

    initial begin
      logic [63:0] eq, er;
      logic        edz, eov;
      int          lat;
      int          mode;

      g_in_valid  = 1'b0;
      g_out_ready = 1'b0;
      g_is_signed = 1'b0;
      g_a         = '0;
      g_b         = '0;
      repeat (8) @(posedge clk);
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        mode        = $urandom_range(0, 7);
        g_is_signed = 1'($urandom_range(0, 1));
        g_a         = GDW'($urandom);
        if (mode == 0) begin
          g_b = '0;
        end else if (mode == 1) begin
          g_is_signed = 1'b1;
          g_a         = {1'b1, {(GDW-1){1'b0}}};
          g_b         = '1;
        end else if (mode < 5) begin
          g_b = GDW'($urandom_range(1, 20));
        end else begin
          g_b = GDW'($urandom);
        end
        g_in_valid = 1'b1;
        @(posedge clk);
        #1;
        g_in_valid = 1'b0;
        chk($sformatf("c%0d_busy", g), 64'(g_in_ready), 64'd0);
        lat = 0;
        while (!g_out_valid && lat < 200) begin
          @(posedge clk);
          lat++;
          #1;
        end
        ref_div(GDW, 64'(g_a), 64'(g_b), g_is_signed, eq, er, edz, eov);
        chk($sformatf("c%0d_lat", g), 64'(lat), 64'(GLAT));
        chk($sformatf("c%0d_q", g), 64'(g_q), eq);
        chk($sformatf("c%0d_r", g), 64'(g_r), er);
        chk($sformatf("c%0d_flags", g), 64'({g_dz, g_ov}), 64'({edz, eov}));
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
        g_out_ready = 1'b1;
        @(posedge clk);
        #1;
        g_out_ready = 1'b0;
        chk($sformatf("c%0d_rdy_after", g), 64'(g_in_ready), 64'd1);
      end
      gen_done++;
    end
  end

endmodule
